// File: rtl/tof_phase_sequencer.sv
// Phase sequencer for the ToF modulation generator: steps DELAY through NUM_PHASES
// offsets per frame, one exposure window per phase followed by a VALID-low gap.
module tof_phase_sequencer #(
  parameter int PH_W = 3,
  parameter int FR_W = 16
) (
  input  logic            CLKIN,
  input  logic            RST,
  input  logic            START,
  input  logic            STOP,
  input  logic [31:0]     PERIOD_IN,
  input  logic [31:0]     DUTY_IN,
  input  logic [31:0]     PHASE_STEP,
  input  logic [PH_W-1:0] NUM_PHASES,
  input  logic [31:0]     EXPO_CYCLES,
  input  logic [31:0]     GAP_CYCLES,
  input  logic [FR_W-1:0] NUM_FRAMES,
  output logic            VALID,
  output logic [31:0]     PERIOD,
  output logic [31:0]     DUTY,
  output logic [31:0]     DELAY,
  output logic [PH_W-1:0] PHASE_IDX,
  output logic            PHASE_START,
  output logic            FRAME_DONE,
  output logic            BUSY,
  output logic            CFG_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPOSE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t          state_r;
  logic            valid_r;
  logic [31:0]     period_r;
  logic [31:0]     duty_r;
  logic [31:0]     delay_r;
  logic [PH_W-1:0] phase_idx_r;
  logic            phase_start_r;
  logic            frame_done_r;
  logic            busy_r;
  logic            cfg_err_r;

  // Latched configuration, stored as terminal counts so compares are plain equality.
  logic [31:0]     step_r;
  logic [31:0]     period_last_r;
  logic [31:0]     expo_last_r;
  logic [31:0]     gap_last_r;
  logic [PH_W-1:0] phase_last_r;
  logic [FR_W-1:0] nframes_r;

  logic [31:0]     dly_cnt_r;
  logic [31:0]     cyc_cnt_r;
  logic [31:0]     per_cnt_r;
  logic [31:0]     gap_cnt_r;
  logic [FR_W-1:0] frame_cnt_r;

  logic            cfg_ok_s;
  logic [31:0]     gap_last_s;
  logic [FR_W-1:0] frame_next_s;
  logic            run_done_s;

  // Start-time configuration checks and derived terminal counts.
  always_comb begin
    cfg_ok_s     = (PERIOD_IN != 32'd0) && (EXPO_CYCLES != 32'd0) &&
                   (NUM_PHASES != {PH_W{1'b0}});
    frame_next_s = frame_cnt_r + FR_W'(1'b1);
    run_done_s   = (nframes_r != {FR_W{1'b0}}) && (frame_next_s == nframes_r);
    if (GAP_CYCLES == 32'd0) begin
      gap_last_s = 32'd0;
    end else begin
      gap_last_s = GAP_CYCLES - 32'd1;
    end
  end

  // Sequencer state machine with all outputs registered.
  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      state_r       <= ST_IDLE;
      valid_r       <= 1'b0;
      period_r      <= 32'd0;
      duty_r        <= 32'd0;
      delay_r       <= 32'd0;
      phase_idx_r   <= {PH_W{1'b0}};
      phase_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      busy_r        <= 1'b0;
      cfg_err_r     <= 1'b0;
      step_r        <= 32'd0;
      period_last_r <= 32'd0;
      expo_last_r   <= 32'd0;
      gap_last_r    <= 32'd0;
      phase_last_r  <= {PH_W{1'b0}};
      nframes_r     <= {FR_W{1'b0}};
      dly_cnt_r     <= 32'd0;
      cyc_cnt_r     <= 32'd0;
      per_cnt_r     <= 32'd0;
      gap_cnt_r     <= 32'd0;
      frame_cnt_r   <= {FR_W{1'b0}};
    end else begin
      phase_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      cfg_err_r     <= 1'b0;
      if (STOP) begin
        state_r     <= ST_IDLE;
        valid_r     <= 1'b0;
        busy_r      <= 1'b0;
        period_r    <= 32'd0;
        duty_r      <= 32'd0;
        delay_r     <= 32'd0;
        phase_idx_r <= {PH_W{1'b0}};
        dly_cnt_r   <= 32'd0;
        cyc_cnt_r   <= 32'd0;
        per_cnt_r   <= 32'd0;
        gap_cnt_r   <= 32'd0;
        frame_cnt_r <= {FR_W{1'b0}};
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (START && cfg_ok_s) begin
              period_r      <= PERIOD_IN;
              duty_r        <= DUTY_IN;
              step_r        <= PHASE_STEP;
              period_last_r <= PERIOD_IN - 32'd1;
              expo_last_r   <= EXPO_CYCLES - 32'd1;
              gap_last_r    <= gap_last_s;
              phase_last_r  <= NUM_PHASES - PH_W'(1'b1);
              nframes_r     <= NUM_FRAMES;
              delay_r       <= 32'd0;
              phase_idx_r   <= {PH_W{1'b0}};
              dly_cnt_r     <= 32'd0;
              cyc_cnt_r     <= 32'd0;
              per_cnt_r     <= 32'd0;
              gap_cnt_r     <= 32'd0;
              frame_cnt_r   <= {FR_W{1'b0}};
              valid_r       <= 1'b1;
              busy_r        <= 1'b1;
              phase_start_r <= 1'b1;
              state_r       <= ST_EXPOSE;
            end else if (START) begin
              cfg_err_r <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_EXPOSE: begin
            // Phase offset first, then EXPO_CYCLES full modulation periods.
            if (dly_cnt_r != delay_r) begin
              dly_cnt_r <= dly_cnt_r + 32'd1;
            end else if (cyc_cnt_r != period_last_r) begin
              cyc_cnt_r <= cyc_cnt_r + 32'd1;
            end else if (per_cnt_r != expo_last_r) begin
              cyc_cnt_r <= 32'd0;
              per_cnt_r <= per_cnt_r + 32'd1;
            end else begin
              cyc_cnt_r <= 32'd0;
              per_cnt_r <= 32'd0;
              dly_cnt_r <= 32'd0;
              gap_cnt_r <= 32'd0;
              valid_r   <= 1'b0;
              state_r   <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (gap_cnt_r != gap_last_r) begin
              gap_cnt_r <= gap_cnt_r + 32'd1;
            end else if (phase_idx_r != phase_last_r) begin
              gap_cnt_r     <= 32'd0;
              phase_idx_r   <= phase_idx_r + PH_W'(1'b1);
              delay_r       <= delay_r + step_r;
              valid_r       <= 1'b1;
              phase_start_r <= 1'b1;
              state_r       <= ST_EXPOSE;
            end else begin
              gap_cnt_r    <= 32'd0;
              frame_done_r <= 1'b1;
              phase_idx_r  <= {PH_W{1'b0}};
              delay_r      <= 32'd0;
              if (run_done_s) begin
                frame_cnt_r <= {FR_W{1'b0}};
                busy_r      <= 1'b0;
                state_r     <= ST_IDLE;
              end else begin
                frame_cnt_r   <= frame_next_s;
                valid_r       <= 1'b1;
                phase_start_r <= 1'b1;
                state_r       <= ST_EXPOSE;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign VALID       = valid_r;
  assign PERIOD      = period_r;
  assign DUTY        = duty_r;
  assign DELAY       = delay_r;
  assign PHASE_IDX   = phase_idx_r;
  assign PHASE_START = phase_start_r;
  assign FRAME_DONE  = frame_done_r;
  assign BUSY        = busy_r;
  assign CFG_ERR     = cfg_err_r;

endmodule

// File: tb/tb_tof_phase_sequencer.sv
// Scoreboard bench for tof_phase_sequencer: stimulus queues expected windows/gaps,
// a negedge monitor measures VALID windows and gaps and compares them.
module tb_tof_phase_sequencer;

  logic        CLKIN = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic [31:0] PERIOD_IN = 32'd0;
  logic [31:0] DUTY_IN = 32'd0;
  logic [31:0] PHASE_STEP = 32'd0;
  logic [2:0]  NUM_PHASES = 3'd0;
  logic [31:0] EXPO_CYCLES = 32'd0;
  logic [31:0] GAP_CYCLES = 32'd0;
  logic [15:0] NUM_FRAMES = 16'd0;
  logic        VALID;
  logic [31:0] PERIOD;
  logic [31:0] DUTY;
  logic [31:0] DELAY;
  logic [2:0]  PHASE_IDX;
  logic        PHASE_START;
  logic        FRAME_DONE;
  logic        BUSY;
  logic        CFG_ERR;

  tof_phase_sequencer #(.PH_W(3), .FR_W(16)) dut (
    .CLKIN(CLKIN), .RST(RST), .START(START), .STOP(STOP),
    .PERIOD_IN(PERIOD_IN), .DUTY_IN(DUTY_IN), .PHASE_STEP(PHASE_STEP),
    .NUM_PHASES(NUM_PHASES), .EXPO_CYCLES(EXPO_CYCLES), .GAP_CYCLES(GAP_CYCLES),
    .NUM_FRAMES(NUM_FRAMES), .VALID(VALID), .PERIOD(PERIOD), .DUTY(DUTY),
    .DELAY(DELAY), .PHASE_IDX(PHASE_IDX), .PHASE_START(PHASE_START),
    .FRAME_DONE(FRAME_DONE), .BUSY(BUSY), .CFG_ERR(CFG_ERR)
  );

  always #5 CLKIN = ~CLKIN;

  typedef struct {
    logic [31:0] delay;
    logic [2:0]  idx;
    int          len;
    bit          abort;
  } win_t;

  win_t exp_win[$];
  int   exp_gap[$];

  int n_tests = 0;
  int n_fail = 0;
  int rises = 0;
  int err_cnt = 0;
  int fd_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push_win(input logic [31:0] d, input logic [2:0] i,
                                   input int len, input bit ab);
    win_t w;
    w.delay = d; w.idx = i; w.len = len; w.abort = ab;
    exp_win.push_back(w);
  endfunction

  // Monitor state
  logic        valid_q = 1'b0;
  int          win_len = 0;
  int          gap_len = 0;
  int          cur_len = 0;
  bit          cur_abort = 1'b1;
  logic [31:0] win_delay = 32'd0;

  always @(negedge CLKIN) begin
    win_t w;
    if (VALID && !valid_q) begin
      rises++;
      chk("phase_start_on_rise", {31'd0, PHASE_START}, 32'd1);
      if (exp_win.size() == 0) begin
        chk("unexpected_window", 32'd1, 32'd0);
        cur_abort = 1'b1;
      end else begin
        w = exp_win.pop_front();
        chk("win_delay", DELAY, w.delay);
        chk("win_idx", {29'd0, PHASE_IDX}, {29'd0, w.idx});
        cur_len = w.len;
        cur_abort = w.abort;
      end
      if (gap_len > 0) begin
        if (exp_gap.size() == 0) chk("unexpected_gap", 32'(gap_len), 32'd0);
        else chk("gap_len", 32'(gap_len), 32'(exp_gap.pop_front()));
      end
      gap_len = 0;
      win_len = 1;
      win_delay = DELAY;
    end else begin
      chk("phase_start_spurious", {31'd0, PHASE_START}, 32'd0);
      if (VALID) begin
        win_len++;
        chk("delay_stable", DELAY, win_delay);
      end else if (valid_q) begin
        if (!cur_abort) chk("win_len", 32'(win_len), 32'(cur_len));
        gap_len = BUSY ? 1 : 0;
      end else begin
        gap_len = BUSY ? gap_len + 1 : 0;
      end
    end
    if (CFG_ERR) err_cnt++;
    if (FRAME_DONE) fd_cnt++;
    valid_q = VALID;
  end

  task automatic set_cfg(input logic [31:0] p, input logic [31:0] d, input logic [31:0] s,
                         input logic [2:0] np, input logic [31:0] e, input logic [31:0] g,
                         input logic [15:0] nf);
    PERIOD_IN = p; DUTY_IN = d; PHASE_STEP = s; NUM_PHASES = np;
    EXPO_CYCLES = e; GAP_CYCLES = g; NUM_FRAMES = nf;
  endtask

  task automatic pulse_start();
    @(posedge CLKIN); #1 START = 1'b1;
    @(posedge CLKIN); #1 START = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge CLKIN); #1 STOP = 1'b1;
    @(posedge CLKIN); #1 STOP = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string nm);
    int k;
    k = 0;
    @(negedge CLKIN);
    while (BUSY && k < max_cyc) begin
      @(negedge CLKIN);
      k++;
    end
    chk({nm, "_idle_timeout"}, {31'd0, BUSY}, 32'd0);
    repeat (2) @(negedge CLKIN);
  endtask

  task automatic wait_rises(input int target, input int max_cyc, input string nm);
    int k;
    k = 0;
    @(negedge CLKIN);
    while (rises < target && k < max_cyc) begin
      @(negedge CLKIN);
      k++;
    end
    chk({nm, "_rise_timeout"}, 32'(rises >= target), 32'd1);
  endtask

  task automatic bad_start(input string nm);
    int eb;
    eb = err_cnt;
    pulse_start();
    @(negedge CLKIN);
    chk({nm, "_cfg_err"}, {31'd0, CFG_ERR}, 32'd1);
    chk({nm, "_valid"}, {31'd0, VALID}, 32'd0);
    chk({nm, "_busy"}, {31'd0, BUSY}, 32'd0);
    @(negedge CLKIN);
    chk({nm, "_cfg_err_once"}, {31'd0, CFG_ERR}, 32'd0);
    @(negedge CLKIN);
    chk({nm, "_err_count"}, 32'(err_cnt - eb), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fb, rb, eb;
    repeat (3) @(posedge CLKIN);
    #1 RST = 1'b0;
    @(negedge CLKIN);
    chk("rst_valid", {31'd0, VALID}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_period", PERIOD, 32'd0);
    chk("rst_duty", DUTY, 32'd0);
    chk("rst_delay", DELAY, 32'd0);
    chk("rst_idx", {29'd0, PHASE_IDX}, 32'd0);
    chk("rst_flags", {29'd0, FRAME_DONE, CFG_ERR, PHASE_START}, 32'd0);

    // Basic frame: windows 12,13,14,15 with DELAY 0..3, 2-cycle gaps
    fb = fd_cnt; eb = err_cnt;
    set_cfg(32'd4, 32'd2, 32'd1, 3'd4, 32'd3, 32'd2, 16'd1);
    for (int i = 0; i < 4; i++) push_win(32'(i), 3'(i), 12 + i, 1'b0);
    for (int i = 0; i < 3; i++) exp_gap.push_back(2);
    pulse_start();
    @(negedge CLKIN);
    chk("t1_period", PERIOD, 32'd4);
    chk("t1_duty", DUTY, 32'd2);
    set_cfg(32'd0, 32'd9, 32'd7, 3'd0, 32'd0, 32'd5, 16'd3);
    repeat (10) @(negedge CLKIN);
    pulse_start();
    wait_idle(200, "t1");
    chk("t1_frame_done", 32'(fd_cnt - fb), 32'd1);
    chk("t1_no_cfg_err", 32'(err_cnt - eb), 32'd0);

    // GAP_CYCLES=0 gives a one-cycle gap
    fb = fd_cnt;
    set_cfg(32'd3, 32'd1, 32'd1, 3'd2, 32'd2, 32'd0, 16'd1);
    push_win(32'd0, 3'd0, 6, 1'b0);
    push_win(32'd1, 3'd1, 7, 1'b0);
    exp_gap.push_back(1);
    pulse_start();
    wait_idle(100, "t2");
    chk("t2_frame_done", 32'(fd_cnt - fb), 32'd1);

    // Continuous run, then STOP mid-EXPOSE of the 7th window
    fb = fd_cnt; rb = rises;
    set_cfg(32'd2, 32'd1, 32'd1, 3'd4, 32'd1, 32'd1, 16'd0);
    for (int i = 0; i < 6; i++) push_win(32'(i % 4), 3'(i % 4), 2 + (i % 4), 1'b0);
    push_win(32'd2, 3'd2, 4, 1'b1);
    for (int i = 0; i < 6; i++) exp_gap.push_back(1);
    pulse_start();
    wait_rises(rb + 7, 200, "t3");
    pulse_stop();
    @(negedge CLKIN);
    chk("t3_stop_valid", {31'd0, VALID}, 32'd0);
    chk("t3_stop_busy", {31'd0, BUSY}, 32'd0);
    repeat (5) @(negedge CLKIN);
    chk("t3_frame_done", 32'(fd_cnt - fb), 32'd1);

    // Rejected starts
    set_cfg(32'd0, 32'd1, 32'd1, 3'd2, 32'd2, 32'd1, 16'd1);
    bad_start("t4_period0");
    set_cfg(32'd4, 32'd1, 32'd1, 3'd0, 32'd2, 32'd1, 16'd1);
    bad_start("t4_phases0");
    set_cfg(32'd4, 32'd1, 32'd1, 3'd2, 32'd0, 32'd1, 16'd1);
    bad_start("t4_expo0");

    // Modular DELAY wrap: 0 then FFFF_FFFF
    rb = rises;
    set_cfg(32'd2, 32'd1, 32'hFFFF_FFFF, 3'd3, 32'd1, 32'd1, 16'd1);
    push_win(32'd0, 3'd0, 2, 1'b0);
    push_win(32'hFFFF_FFFF, 3'd1, 0, 1'b1);
    exp_gap.push_back(1);
    pulse_start();
    wait_rises(rb + 2, 50, "t5");
    @(negedge CLKIN);
    chk("t5_wrap_delay", DELAY, 32'hFFFF_FFFF);
    pulse_stop();
    @(negedge CLKIN);
    chk("t5_stop_busy", {31'd0, BUSY}, 32'd0);

    // Async reset mid-phase, then a clean restart
    rb = rises;
    set_cfg(32'd4, 32'd2, 32'd1, 3'd2, 32'd3, 32'd2, 16'd1);
    push_win(32'd0, 3'd0, 0, 1'b1);
    pulse_start();
    wait_rises(rb + 1, 20, "t6");
    @(posedge CLKIN);
    #2 RST = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, VALID}, 32'd0);
    chk("t6_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("t6_rst_period", PERIOD, 32'd0);
    chk("t6_rst_delay", DELAY, 32'd0);
    @(posedge CLKIN);
    #1 RST = 1'b0;
    fb = fd_cnt;
    set_cfg(32'd4, 32'd2, 32'd1, 3'd1, 32'd3, 32'd0, 16'd1);
    push_win(32'd0, 3'd0, 12, 1'b0);
    pulse_start();
    wait_idle(100, "t6");
    chk("t6_frame_done", 32'(fd_cnt - fb), 32'd1);

    chk("win_queue_empty", 32'(exp_win.size()), 32'd0);
    chk("gap_queue_empty", 32'(exp_gap.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
